peripheral_ahb3_spram_master: RTL and testbench

//  AHB3-Lite single-transfer master that drives the peripheral_ahb3_spram slave.

---
 rtl/peripheral_ahb3_pkg.sv | 24 ++
 rtl/peripheral_ahb3_spram_master.sv | 133 +++++++++++++
 tb/tb_peripheral_ahb3_spram_master.sv | 312 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/peripheral_ahb3_pkg.sv
// Shared AHB3-Lite encodings and the master's data-phase state type.
package peripheral_ahb3_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic [2:0] HBURST_INCR   = 3'b001;

  localparam logic [2:0] HSIZE_BYTE  = 3'b000;
  localparam logic [2:0] HSIZE_HWORD = 3'b001;
  localparam logic [2:0] HSIZE_WORD  = 3'b010;
  localparam logic [2:0] HSIZE_DWORD = 3'b011;

  typedef enum logic [1:0] {
    DP_IDLE = 2'd0,
    DP_RD   = 2'd1,
    DP_WR   = 2'd2,
    DP_ERR1 = 2'd3
  } dp_state_t;

endpackage

// File: rtl/peripheral_ahb3_spram_master.sv
// AHB3-Lite single-transfer master: native valid/ready requests in, pipelined
// NONSEQ transfers out, one in-order response per request.
module peripheral_ahb3_spram_master
  import peripheral_ahb3_pkg::*;
#(
  parameter int XLEN = 64,
  parameter int PLEN = 64,
  parameter logic [3:0] HPROT_VAL = 4'b0011
) (
  input  logic            HCLK,
  input  logic            HRESET,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_we,
  input  logic [PLEN-1:0] req_addr,
  input  logic [2:0]      req_size,
  input  logic [XLEN-1:0] req_wdata,
  output logic            rsp_valid,
  output logic [XLEN-1:0] rsp_rdata,
  output logic            rsp_err,
  output logic            HSEL,
  output logic [PLEN-1:0] HADDR,
  output logic [XLEN-1:0] HWDATA,
  input  logic [XLEN-1:0] HRDATA,
  output logic            HWRITE,
  output logic [2:0]      HSIZE,
  output logic [2:0]      HBURST,
  output logic [3:0]      HPROT,
  output logic [1:0]      HTRANS,
  output logic            HMASTLOCK,
  input  logic            HREADY,
  input  logic            HRESP
);

  // Handshake: a request transfers on a rising edge where req_valid & req_ready;
  // responses are a single-cycle rsp_valid strobe with no backpressure.

  dp_state_t       dp_state, dp_next;
  logic [XLEN-1:0] ap_wdata;
  logic            cancelled;
  logic            cancel_rsp;
  logic            ap_pending;
  logic            dp_busy;
  logic            dp_done;
  logic            dp_fault;
  logic            accept;

  assign ap_pending = (HTRANS == HTRANS_NONSEQ);
  assign dp_busy    = (dp_state == DP_RD) || (dp_state == DP_WR);
  assign dp_done    = dp_busy & HREADY;
  assign dp_fault   = dp_busy & ~HREADY & HRESP;

  assign req_ready = HREADY & ~HRESET & (dp_state != DP_ERR1);
  assign accept    = req_valid & req_ready;

  assign HSEL      = (HTRANS != HTRANS_IDLE);
  assign HBURST    = HBURST_SINGLE;
  assign HPROT     = HPROT_VAL;
  assign HMASTLOCK = 1'b0;

  always_comb begin
    dp_next = dp_state;
    case (dp_state)
      DP_IDLE, DP_RD, DP_WR: begin
        if (dp_fault)
          dp_next = DP_ERR1;
        else if (HREADY)
          dp_next = ap_pending ? (HWRITE ? DP_WR : DP_RD) : DP_IDLE;
      end
      DP_ERR1: begin
        if (HREADY) dp_next = DP_IDLE;
      end
      default: dp_next = DP_IDLE;
    endcase
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      dp_state   <= DP_IDLE;
      HTRANS     <= HTRANS_IDLE;
      HADDR      <= '0;
      HWRITE     <= 1'b0;
      HSIZE      <= '0;
      HWDATA     <= '0;
      ap_wdata   <= '0;
      rsp_valid  <= 1'b0;
      rsp_err    <= 1'b0;
      rsp_rdata  <= '0;
      cancelled  <= 1'b0;
      cancel_rsp <= 1'b0;
    end else begin
      dp_state   <= dp_next;
      rsp_valid  <= 1'b0;
      rsp_err    <= 1'b0;
      cancel_rsp <= 1'b0;

      // First ERROR cycle: drop the queued address phase before the slave samples it.
      if (dp_fault) begin
        HTRANS    <= HTRANS_IDLE;
        cancelled <= ap_pending;
      end else if (HREADY) begin
        if (ap_pending && HWRITE) HWDATA <= ap_wdata;
        if (accept) begin
          HTRANS   <= HTRANS_NONSEQ;
          HADDR    <= req_addr;
          HWRITE   <= req_we;
          HSIZE    <= req_size;
          ap_wdata <= req_wdata;
        end else begin
          HTRANS <= HTRANS_IDLE;
        end
      end

      if (dp_done) begin
        rsp_valid <= 1'b1;
        rsp_err   <= HRESP;
        rsp_rdata <= (dp_state == DP_RD && !HRESP) ? HRDATA : '0;
      end else if (dp_state == DP_ERR1 && HREADY) begin
        rsp_valid  <= 1'b1;
        rsp_err    <= 1'b1;
        rsp_rdata  <= '0;
        cancel_rsp <= cancelled;
        cancelled  <= 1'b0;
      end else if (cancel_rsp) begin
        // The cancelled transfer still owes its requester an (error) response.
        rsp_valid <= 1'b1;
        rsp_err   <= 1'b1;
        rsp_rdata <= '0;
      end
    end
  end

endmodule

// File: tb/tb_peripheral_ahb3_spram_master.sv
// Bench for peripheral_ahb3_spram_master with a small AHB memory slave model
// that stalls reads of 0x100 and answers 0x200 with a two-cycle ERROR.
module tb_peripheral_ahb3_spram_master;

  localparam logic [63:0] STALL_ADDR = 64'h100;
  localparam logic [63:0] ERR_ADDR   = 64'h200;
  localparam logic [1:0]  NONSEQ     = 2'b10;

  logic        HCLK = 1'b0;
  logic        HRESET = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [63:0] req_addr = '0;
  logic [2:0]  req_size = '0;
  logic [63:0] req_wdata = '0;
  logic        rsp_valid;
  logic [63:0] rsp_rdata;
  logic        rsp_err;
  logic        HSEL;
  logic [63:0] HADDR;
  logic [63:0] HWDATA;
  logic [63:0] HRDATA;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [2:0]  HBURST;
  logic [3:0]  HPROT;
  logic [1:0]  HTRANS;
  logic        HMASTLOCK;
  logic        HREADY;
  logic        HRESP;

  int n_checks = 0;
  int n_pass   = 0;
  logic [64:0] exp_q[$];
  logic [63:0] tbl [4];
  logic [63:0] prev_addr;

  peripheral_ahb3_spram_master #(.XLEN(64), .PLEN(64), .HPROT_VAL(4'b0011)) dut (
    .HCLK(HCLK), .HRESET(HRESET),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_size(req_size), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .HSEL(HSEL), .HADDR(HADDR), .HWDATA(HWDATA), .HRDATA(HRDATA),
    .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST), .HPROT(HPROT),
    .HTRANS(HTRANS), .HMASTLOCK(HMASTLOCK), .HREADY(HREADY), .HRESP(HRESP)
  );

  // ---------------- clock / watchdog ----------------
  always #5 HCLK = ~HCLK;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, required finish before it");
    $fatal(1, "watchdog");
  end

  // ---------------- slave model ----------------
  logic [63:0] mem [0:63];
  logic        s_active = 1'b0;
  logic        s_write = 1'b0;
  logic        s_err = 1'b0;
  logic        s_err_stage = 1'b0;
  logic [63:0] s_addr = '0;
  int          s_wait = 0;

  always_comb begin
    HREADY = 1'b1;
    HRESP  = 1'b0;
    HRDATA = '0;
    if (s_active) begin
      if (s_err) begin
        HRESP  = 1'b1;
        HREADY = s_err_stage;
      end else if (s_wait > 0) begin
        HREADY = 1'b0;
      end
      if (!s_write) HRDATA = mem[s_addr[8:3]];
    end
  end

  always @(posedge HCLK) begin
    if (HRESET) begin
      s_active <= 1'b0;
      s_err <= 1'b0;
      s_err_stage <= 1'b0;
      s_wait <= 0;
    end else if (!HREADY) begin
      if (s_wait > 0) s_wait <= s_wait - 1;
      if (s_err) s_err_stage <= 1'b1;
    end else begin
      if (s_active && s_write && !s_err) mem[s_addr[8:3]] <= HWDATA;
      s_active    <= HSEL && (HTRANS == NONSEQ);
      s_addr      <= HADDR;
      s_write     <= HWRITE;
      s_wait      <= (HSEL && HTRANS == NONSEQ && !HWRITE && HADDR == STALL_ADDR) ? 3 : 0;
      s_err       <= HSEL && (HTRANS == NONSEQ) && (HADDR == ERR_ADDR);
      s_err_stage <= 1'b0;
    end
  end

  // Requests must be aligned and no wider than the bus.
  always @(posedge HCLK) begin
    if (req_valid && req_ready)
      assert (req_size <= 3'd3 && (req_addr & ((64'd1 << req_size) - 64'd1)) == 64'd0)
        else $error("misaligned or oversize request addr=%h size=%0d", req_addr, req_size);
  end

  // ---------------- checking ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h, required %h (t=%0t)", name, act, req, $time);
  endtask

  always @(negedge HCLK) begin
    logic [64:0] e;
    if (rsp_valid) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL rsp_unexpected: got err=%0b rdata=%h, required no response (t=%0t)",
                 rsp_err, rsp_rdata, $time);
      end else begin
        e = exp_q.pop_front();
        chk("rsp_err", 64'(rsp_err), 64'(e[64]));
        chk("rsp_rdata", rsp_rdata, e[63:0]);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input logic we, input logic [63:0] addr, input logic [63:0] wdata);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_size  = 3'd3;
    req_wdata = wdata;
  endtask

  task automatic send_one(input logic we, input logic [63:0] addr, input logic [63:0] wdata,
                          input logic exp_err, input logic [63:0] exp_rdata);
    int n = 0;
    exp_q.push_back({exp_err, exp_rdata});
    @(posedge HCLK); #1;
    drive(we, addr, wdata);
    @(negedge HCLK);
    while (!req_ready && n < 50) begin
      @(negedge HCLK);
      n++;
    end
    if (!req_ready) chk("accept_timeout", 64'(req_ready), 64'd1);
    @(posedge HCLK); #1;
    req_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 40) begin
      @(negedge HCLK);
      n++;
    end
    chk(name, 64'(exp_q.size()), 64'd0);
    repeat (2) @(negedge HCLK);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    tbl[0] = 64'h1111_2222_3333_4444;
    tbl[1] = 64'h5555_6666_7777_8888;
    tbl[2] = 64'h9999_AAAA_BBBB_CCCC;
    tbl[3] = 64'hDDDD_EEEE_FFFF_0000;

    repeat (3) @(posedge HCLK);
    #1 HRESET = 1'b0;
    @(negedge HCLK);
    chk("rst_htrans", 64'(HTRANS), 64'd0);
    chk("rst_hsel", 64'(HSEL), 64'd0);
    chk("rst_hwrite", 64'(HWRITE), 64'd0);
    chk("rst_haddr", HADDR, 64'd0);
    chk("rst_hwdata", HWDATA, 64'd0);
    chk("rst_hsize", 64'(HSIZE), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_rsp_err", 64'(rsp_err), 64'd0);
    chk("rst_rsp_rdata", rsp_rdata, 64'd0);
    chk("hburst", 64'(HBURST), 64'd0);
    chk("hprot", 64'(HPROT), 64'd3);
    chk("hmastlock", 64'(HMASTLOCK), 64'd0);
    chk("rst_req_ready", 64'(req_ready), 64'd1);

    // single write: address phase at N+1, response at N+3
    send_one(1'b1, 64'h10, 64'hDEADBEEF_CAFEF00D, 1'b0, 64'd0);
    @(negedge HCLK);
    chk("wr_htrans", 64'(HTRANS), 64'(NONSEQ));
    chk("wr_haddr", HADDR, 64'h10);
    chk("wr_hwrite", 64'(HWRITE), 64'd1);
    chk("wr_hsize", 64'(HSIZE), 64'd3);
    chk("wr_hsel", 64'(HSEL), 64'd1);
    @(negedge HCLK);
    chk("wr_rsp_early", 64'(rsp_valid), 64'd0);
    chk("wr_hwdata", HWDATA, 64'hDEADBEEF_CAFEF00D);
    @(negedge HCLK);
    chk("wr_rsp_n3", 64'(rsp_valid), 64'd1);
    drain("wr_drain");

    send_one(1'b0, 64'h10, '0, 1'b0, 64'hDEADBEEF_CAFEF00D);
    drain("rd_drain");

    // back-to-back: 4 writes then 4 reads, one NONSEQ per cycle
    @(posedge HCLK); #1;
    for (int i = 0; i < 8; i++) begin
      if (i < 4) begin
        exp_q.push_back({1'b0, 64'd0});
        drive(1'b1, 64'(8 * i), tbl[i]);
      end else begin
        exp_q.push_back({1'b0, tbl[i-4]});
        drive(1'b0, 64'(8 * (i - 4)), '0);
      end
      @(negedge HCLK);
      chk("b2b_ready", 64'(req_ready), 64'd1);
      if (i > 0) begin
        chk("b2b_htrans", 64'(HTRANS), 64'(NONSEQ));
        chk("b2b_haddr", HADDR, prev_addr);
      end
      prev_addr = req_addr;
      @(posedge HCLK); #1;
    end
    req_valid = 1'b0;
    @(negedge HCLK);
    chk("b2b_htrans_last", 64'(HTRANS), 64'(NONSEQ));
    chk("b2b_haddr_last", HADDR, 64'h18);
    drain("b2b_drain");

    // wait states: read 0x100 stalls 3 cycles with read 0x10 queued behind it
    send_one(1'b1, STALL_ADDR, 64'h01234567_89ABCDEF, 1'b0, 64'd0);
    drain("stall_pre_drain");
    exp_q.push_back({1'b0, 64'h01234567_89ABCDEF});
    exp_q.push_back({1'b0, tbl[2]});
    @(posedge HCLK); #1;
    drive(1'b0, STALL_ADDR, '0);
    @(negedge HCLK);
    chk("stall_acc0", 64'(req_ready), 64'd1);
    @(posedge HCLK); #1;
    drive(1'b0, 64'h10, '0);
    @(negedge HCLK);
    chk("stall_acc1", 64'(req_ready), 64'd1);
    @(posedge HCLK); #1;
    req_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge HCLK);
      chk("stall_htrans", 64'(HTRANS), 64'(NONSEQ));
      chk("stall_haddr", HADDR, 64'h10);
      chk("stall_ready", 64'(req_ready), 64'd0);
      chk("stall_rsp", 64'(rsp_valid), 64'd0);
    end
    @(negedge HCLK);
    chk("stall_rsp_n5", 64'(rsp_valid), 64'd0);
    @(negedge HCLK);
    chk("stall_rsp_n6", 64'(rsp_valid), 64'd1);
    drain("stall_drain");

    // ERROR on read 0x200 with read 0x10 pending: both end in error
    exp_q.push_back({1'b1, 64'd0});
    exp_q.push_back({1'b1, 64'd0});
    @(posedge HCLK); #1;
    drive(1'b0, ERR_ADDR, '0);
    @(negedge HCLK);
    @(posedge HCLK); #1;
    drive(1'b0, 64'h10, '0);
    @(negedge HCLK);
    chk("err_acc1", 64'(req_ready), 64'd1);
    @(posedge HCLK); #1;
    req_valid = 1'b0;
    @(negedge HCLK);
    chk("err1_htrans", 64'(HTRANS), 64'(NONSEQ));
    chk("err1_ready", 64'(req_ready), 64'd0);
    @(negedge HCLK);
    chk("err2_htrans_cancel", 64'(HTRANS), 64'd0);
    chk("err2_hsel", 64'(HSEL), 64'd0);
    chk("err2_ready", 64'(req_ready), 64'd0);
    chk("err2_rsp", 64'(rsp_valid), 64'd0);
    @(negedge HCLK);
    chk("err_rsp_a", 64'({rsp_valid, rsp_err}), 64'd3);
    @(negedge HCLK);
    chk("err_rsp_b", 64'({rsp_valid, rsp_err}), 64'd3);
    @(negedge HCLK);
    chk("err_rsp_after", 64'(rsp_valid), 64'd0);
    drain("err_drain");
    send_one(1'b0, 64'h10, '0, 1'b0, tbl[2]);
    drain("err_recover_drain");

    // reset during the data phase of a write: abandoned, no response
    send_one(1'b1, 64'h18, 64'hBAD0_BAD0_BAD0_BAD0, 1'b0, 64'd0);
    void'(exp_q.pop_back());
    @(posedge HCLK); #1;
    HRESET = 1'b1;
    @(negedge HCLK);
    chk("rst_mid_ready", 64'(req_ready), 64'd0);
    @(negedge HCLK);
    chk("rst_mid_htrans", 64'(HTRANS), 64'd0);
    chk("rst_mid_hsel", 64'(HSEL), 64'd0);
    chk("rst_mid_rsp", 64'(rsp_valid), 64'd0);
    chk("rst_mid_haddr", HADDR, 64'd0);
    @(posedge HCLK); #1;
    HRESET = 1'b0;
    repeat (6) @(negedge HCLK);
    drain("final_drain");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
